// File: rtl/mem_io_ctrl_if.sv
// CPU-side memory handshake between the control unit and mem_io_ctrl.
// master = control unit (issues requests), slave = memory controller.
interface mem_io_ctrl_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;

  modport master (
    output Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// SRAM / memory-mapped I/O access sequencer: one access per request level,
// fixed strobe width of WAIT_CYCLES+1 cycles, registered SRAM strobes.
//
// state  | meaning
// IDLE   | waiting for Mem_OE / Mem_WE
// RD_ACT | SRAM read strobes active, wait counter running
// WR_ACT | SRAM write strobes active, data bus driven
// IO_ACT | address 16'hFFFF: no SRAM strobes, switches / hex register access
// DONE   | Mem_Ready pulse; write data still held on the bus after SRAM write
// HOLD   | waiting for the request to drop before accepting another
module mem_io_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_io_ctrl_if.slave        cpu,
  input  logic [15:0]         Switches,
  output logic [15:0]         HEX_Data,
  output logic [19:0]         SRAM_ADDR,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic [15:0]         SRAM_DQ_out,
  output logic                SRAM_DQ_oe,
  input  logic [15:0]         SRAM_DQ_in
);

  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    WR_ACT,
    IO_ACT,
    DONE,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        start;
  logic        last;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic [15:0] d2c_q;
  logic [15:0] hex_q;
  logic        ready_q;
  logic        ce_n_q, oe_n_q, we_n_q;
  logic        dq_oe_q;

  logic        sram_sel_d;
  logic        oe_n_d, we_n_d;
  logic        dq_oe_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Down-counter loaded on leaving IDLE; terminal count ends the strobe window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu.Mem_WE || cpu.Mem_OE) begin
          start = 1'b1;
          cnt_d = WAIT_LD;
          if (cpu.ADDR == IO_ADDR)
            state_d = IO_ACT;
          else if (cpu.Mem_WE)
            state_d = WR_ACT;
          else
            state_d = RD_ACT;
        end
      end
      RD_ACT, WR_ACT, IO_ACT: begin
        if (cnt_q == 4'd0) begin
          last    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = HOLD;
      HOLD: begin
        if (!cpu.Mem_OE && !cpu.Mem_WE)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_comb begin
    sram_sel_d = (state_d == RD_ACT) || (state_d == WR_ACT);
    oe_n_d     = !(state_d == RD_ACT);
    we_n_d     = !(state_d == WR_ACT);
    dq_oe_d    = (state_d == WR_ACT) || ((state_q == WR_ACT) && (state_d == DONE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      wr_q    <= 1'b0;
      d2c_q   <= 16'd0;
      hex_q   <= 16'd0;
      ready_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= cpu.ADDR;
        wdata_q <= cpu.Data_from_CPU;
        wr_q    <= cpu.Mem_WE;
      end
      if (last && (state_q == RD_ACT))
        d2c_q <= SRAM_DQ_in;
      else if (last && (state_q == IO_ACT) && !wr_q)
        d2c_q <= Switches;
      if (last && (state_q == IO_ACT) && wr_q)
        hex_q <= wdata_q;
      ready_q <= (state_d == DONE);
      ce_n_q  <= !sram_sel_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign cpu.Data_to_CPU = d2c_q;
  assign cpu.Mem_Ready   = ready_q;
  assign HEX_Data        = hex_q;
  assign SRAM_ADDR       = {4'b0000, addr_q};
  assign SRAM_CE_N       = ce_n_q;
  assign SRAM_OE_N       = oe_n_q;
  assign SRAM_WE_N       = we_n_q;
  assign SRAM_UB_N       = ce_n_q;
  assign SRAM_LB_N       = ce_n_q;
  assign SRAM_DQ_out     = wdata_q;
  assign SRAM_DQ_oe      = dq_oe_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Random and directed accesses against two controllers (W=2 and W=0) sharing
// one request stream, checked against an array-based model of memory and I/O.
module tb_mem_io_ctrl;
  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        mem_load;
  logic [15:0] Switches;

  logic [15:0] hex_data,  hex_data0;
  logic [19:0] sram_addr, sram_addr0;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic        ce0_n, oe0_n, we0_n, ub0_n, lb0_n;
  logic [15:0] dq_out, dq_out0, dq_in, dq_in0;
  logic        dq_oe, dq_oe0;

  logic [15:0] sram  [256];
  logic [15:0] sram0 [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_d2c, exp_hex;

  int n_total = 0;
  int n_bad   = 0;

  mem_io_ctrl_if bus ();
  mem_io_ctrl_if bus0 ();

  assign bus0.Mem_OE        = bus.Mem_OE;
  assign bus0.Mem_WE        = bus.Mem_WE;
  assign bus0.ADDR          = bus.ADDR;
  assign bus0.Data_from_CPU = bus.Data_from_CPU;

  always #5 Clk = ~Clk;

  mem_io_ctrl #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .cpu(bus), .Switches(Switches), .HEX_Data(hex_data),
    .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DQ_out(dq_out), .SRAM_DQ_oe(dq_oe),
    .SRAM_DQ_in(dq_in)
  );

  mem_io_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .cpu(bus0), .Switches(Switches), .HEX_Data(hex_data0),
    .SRAM_ADDR(sram_addr0), .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe0_n), .SRAM_WE_N(we0_n),
    .SRAM_UB_N(ub0_n), .SRAM_LB_N(lb0_n), .SRAM_DQ_out(dq_out0), .SRAM_DQ_oe(dq_oe0),
    .SRAM_DQ_in(dq_in0)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37) ^ 16'hC3A5;
  endfunction

  // Behavioural SRAMs: asynchronous read, write on a clock edge while WE_N is low.
  assign dq_in  = sram[sram_addr[7:0]];
  assign dq_in0 = sram0[sram_addr0[7:0]];

  always @(posedge Clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        sram[i]  <= init_val(i);
        sram0[i] <= init_val(i);
      end
    end else begin
      if (!ce_n && !we_n && dq_oe)
        sram[sram_addr[7:0]] <= dq_out;
      if (!ce0_n && !we0_n && dq_oe0)
        sram0[sram_addr0[7:0]] <= dq_out0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_access(input logic we, input logic oe, input logic [15:0] addr,
                            input logic [15:0] wdata, input int hold);
    int   n_cyc, rdy_n, rdy_at, ce_lo, oe_lo, we_lo, bl_lo, oe_hi, first_ce;
    int   rdy0_n, rdy0_at, ce0_lo;
    logic is_wr, is_sram, addr_bad, dq_bad;
    is_wr   = we;
    is_sram = (addr != 16'hFFFF);
    n_cyc   = ((hold > W + 2) ? hold : W + 2) + 3;
    rdy_n = 0; rdy_at = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; bl_lo = 0; oe_hi = 0;
    first_ce = 0; rdy0_n = 0; rdy0_at = 0; ce0_lo = 0;
    addr_bad = 1'b0; dq_bad = 1'b0;
    @(negedge Clk);
    Switches          = 16'($urandom);
    bus.Mem_WE        = we;
    bus.Mem_OE        = oe;
    bus.ADDR          = addr;
    bus.Data_from_CPU = wdata;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge Clk); #1;
      if (!ce_n) begin
        ce_lo++;
        if (first_ce == 0) first_ce = k;
      end
      if (!oe_n) oe_lo++;
      if (!we_n) we_lo++;
      if (!ub_n && !lb_n) bl_lo++;
      if (dq_oe) begin
        oe_hi++;
        if (dq_out !== wdata) dq_bad = 1'b1;
      end
      if (k <= W + 2 && sram_addr !== {4'h0, addr}) addr_bad = 1'b1;
      if (bus.Mem_Ready) begin rdy_n++; rdy_at = k; end
      if (bus0.Mem_Ready) begin rdy0_n++; rdy0_at = k; end
      if (!ce0_n) ce0_lo++;
      if (k == hold) begin
        bus.Mem_WE = 1'b0;
        bus.Mem_OE = 1'b0;
      end
    end
    if (is_wr) begin
      if (is_sram) ref_mem[addr[7:0]] = wdata;
      else         exp_hex = wdata;
    end else begin
      exp_d2c = is_sram ? ref_mem[addr[7:0]] : Switches;
    end
    check_val("ready_count",   rdy_n,  1);
    check_val("ready_cycle",   rdy_at, W + 2);
    check_val("ce_cycles",     ce_lo,  is_sram ? W + 1 : 0);
    check_val("ce_first",      first_ce, is_sram ? 1 : 0);
    check_val("oe_cycles",     oe_lo,  (is_sram && !is_wr) ? W + 1 : 0);
    check_val("we_cycles",     we_lo,  (is_sram && is_wr) ? W + 1 : 0);
    check_val("ublb_cycles",   bl_lo,  is_sram ? W + 1 : 0);
    check_val("dq_oe_cycles",  oe_hi,  (is_sram && is_wr) ? W + 2 : 0);
    check_val("dq_out_value",  dq_bad, 0);
    check_val("sram_addr",     addr_bad, 0);
    check_val("data_to_cpu",   bus.Data_to_CPU, exp_d2c);
    check_val("hex_data",      hex_data, exp_hex);
    check_val("w0_ready_count", rdy0_n, 1);
    check_val("w0_ready_cycle", rdy0_at, 2);
    check_val("w0_ce_cycles",  ce0_lo, is_sram ? 1 : 0);
    check_val("w0_data_to_cpu", bus0.Data_to_CPU, exp_d2c);
    check_val("w0_hex_data",   hex_data0, exp_hex);
  endtask

  task automatic reset_mid_read(input logic [15:0] addr);
    int rdy_n, rdy_at;
    rdy_n = 0; rdy_at = 0;
    @(negedge Clk);
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b0;
    bus.ADDR   = addr;
    @(posedge Clk); #1;
    check_val("rst_first_strobe", oe_n, 0);
    @(posedge Clk); #1;
    check_val("rst_second_strobe", oe_n, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_val("rst_strobes_off", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check_val("rst_dq_oe", dq_oe, 0);
    check_val("rst_no_ready", bus.Mem_Ready, 0);
    check_val("rst_d2c_clear", bus.Data_to_CPU, 16'h0000);
    check_val("rst_hex_clear", hex_data, 16'h0000);
    check_val("rst_w0_d2c_clear", bus0.Data_to_CPU, 16'h0000);
    exp_d2c = 16'h0000;
    exp_hex = 16'h0000;
    @(posedge Clk); #1;
    check_val("rst_no_ready_2", bus.Mem_Ready, 0);
    Reset = 1'b0;
    // Request is still high: a fresh access must start from IDLE.
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge Clk); #1;
      if (bus.Mem_Ready) begin rdy_n++; rdy_at = k; end
      if (k == W + 2) begin
        bus.Mem_OE = 1'b0;
      end
    end
    repeat (3) @(posedge Clk);
    #1;
    exp_d2c = ref_mem[addr[7:0]];
    check_val("restart_ready_count", rdy_n, 1);
    check_val("restart_ready_cycle", rdy_at, W + 2);
    check_val("restart_d2c", bus.Data_to_CPU, exp_d2c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we, oe;
    logic [15:0] addr;
    Reset = 1'b1;
    mem_load = 1'b1;
    Switches = 16'h0000;
    bus.Mem_OE = 1'b0;
    bus.Mem_WE = 1'b0;
    bus.ADDR = 16'h0000;
    bus.Data_from_CPU = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    exp_d2c = 16'h0000;
    exp_hex = 16'h0000;
    @(posedge Clk); #1;
    mem_load = 1'b0;
    @(posedge Clk); #1;
    check_val("reset_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check_val("reset_dq", {dq_oe, dq_out}, 17'h0);
    check_val("reset_sram_addr", sram_addr, 20'h0);
    check_val("reset_d2c", bus.Data_to_CPU, 16'h0);
    check_val("reset_hex", hex_data, 16'h0);
    check_val("reset_ready", bus.Mem_Ready, 0);
    @(negedge Clk);
    Reset = 1'b0;

    run_access(1'b1, 1'b0, 16'h0012, 16'hBEEF, 1);
    run_access(1'b0, 1'b1, 16'h0012, 16'h5555, 3);
    check_val("read_beef", bus.Data_to_CPU, 16'hBEEF);
    run_access(1'b1, 1'b0, 16'h0034, 16'h1234, 3);
    run_access(1'b1, 1'b1, 16'h0040, 16'h7E57, 2);
    check_val("both_high_d2c_kept", bus.Data_to_CPU, 16'hBEEF);
    run_access(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 2);
    check_val("io_hex_a5", hex_data, 16'h00A5);
    @(negedge Clk);
    run_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 2);
    run_access(1'b0, 1'b1, 16'h0040, 16'h0000, 10);
    check_val("read_back_7e57", bus.Data_to_CPU, 16'h7E57);

    for (int n = 0; n < 40; n++) begin
      we   = 1'($urandom_range(0, 1));
      oe   = we ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = ($urandom_range(0, 4) == 0) ? 16'hFFFF
           : (16'($urandom_range(0, 15)) | (16'($urandom_range(0, 1)) << 12));
      run_access(we, oe, addr, 16'($urandom), int'($urandom_range(1, 12)));
    end

    reset_mid_read(16'h0034);
    run_access(1'b0, 1'b1, 16'h0012, 16'h0000, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra SRAM strobe cycles per access (legal 0..15).
REQ-002 Clk  in  1  system clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Mem_OE  in  1  read request (level) from control unit.
REQ-005 Mem_WE  in  1  write request (level) from control unit.
REQ-006 ADDR  in  16  access address (MAR).
REQ-007 Data_from_CPU  in  16  write data (MDR).
REQ-008 Data_to_CPU  out  16  registered read data for MDR load.
REQ-009 Mem_Ready  out  1  one-cycle access-complete pulse.
REQ-010 Switches  in  16  board switches, memory-mapped read source.
REQ-011 HEX_Data  out  16  registered memory-mapped hex display value.
REQ-012 SRAM_ADDR  out  20  SRAM address.
REQ-013 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes, all registered.
REQ-014 SRAM_DQ_out  out  16  write data driven to SRAM data bus.
REQ-015 SRAM_DQ_oe  out  1  data-bus drive enable (1 = drive SRAM_DQ_out).
REQ-016 SRAM_DQ_in  in  16  data sampled from SRAM data bus.

Function
REQ-017 FSM states: IDLE, RD_ACT, WR_ACT, IO_ACT, DONE, HOLD.
REQ-018 IDLE: Mem_WE=1 at an edge -> WR_ACT (or IO_ACT if ADDR=16'hFFFF); else Mem_OE=1 -> RD_ACT (or IO_ACT if ADDR=16'hFFFF); WE wins if both high.
REQ-019 On leaving IDLE: capture ADDR, Data_from_CPU, and access type; load 4-bit counter with WAIT_CYCLES.
REQ-020 Request first sampled at edge t: strobes active cycles t+1..t+W+1 (W = WAIT_CYCLES), W+1 cycles total.
REQ-021 RD_ACT: CE_N=OE_N=UB_N=LB_N=0, WE_N=1, DQ_oe=0; counter decrements each cycle; at counter=0, Data_to_CPU <= SRAM_DQ_in on that edge, go DONE.
REQ-022 WR_ACT: CE_N=WE_N=UB_N=LB_N=0, OE_N=1, DQ_oe=1, DQ_out=captured data; at counter=0 go DONE.
REQ-023 Write data hold: DQ_oe stays 1 and DQ_out unchanged during DONE after write, with all strobes inactive.
REQ-024 IO_ACT: no SRAM strobe asserted, DQ_oe=0; same counter timing; at counter=0 read gives Data_to_CPU <= Switches, write gives HEX_Data <= captured data.
REQ-025 DONE (cycle t+W+2): Mem_Ready=1 for exactly this cycle, then -> HOLD.
REQ-026 HOLD: stays until Mem_OE=0 and Mem_WE=0 at an edge, then -> IDLE; no new access starts from a still-held request.
REQ-027 SRAM_ADDR = {4'b0000, captured ADDR}, constant through the access.
REQ-028 Outside active windows: CE_N=OE_N=WE_N=UB_N=LB_N=1; DQ_oe=0 except REQ-023.
REQ-029 Request deasserted mid-access: access completes unchanged; Mem_Ready still pulses.
REQ-030 Data_to_CPU holds last read value until the next read completes; writes do not change it.
REQ-031 HEX_Data changes only on I/O write completion.
REQ-032 WAIT_CYCLES=0: single strobe cycle, Mem_Ready at t+2.

Reset
REQ-033 Reset=1 at an edge: state IDLE, counter 0, all SRAM strobes 1, DQ_oe=0, DQ_out=0, SRAM_ADDR=0, Data_to_CPU=0, HEX_Data=0, Mem_Ready=0.
REQ-034 Reset mid-access aborts it: strobes inactive and DQ_oe=0 on the following cycle; no Mem_Ready; Data_to_CPU/HEX_Data cleared, not updated.
REQ-035 After reset release, a request still high starts a new access from IDLE.

Verification
REQ-036 W=2, Mem_OE held 3 cycles, ADDR=16'h0012, SRAM_DQ_in=16'hBEEF -> CE_N/OE_N low 3 cycles, SRAM_ADDR=20'h00012, Data_to_CPU=16'hBEEF and Mem_Ready pulse at t+4.
REQ-037 W=2, Mem_WE, ADDR=16'h0034, data 16'h1234 -> WE_N low 3 cycles, DQ_oe high 4 cycles with DQ_out=16'h1234, OE_N stays 1, Mem_Ready at t+4.
REQ-038 Mem_OE and Mem_WE both high at IDLE -> write performed, Data_to_CPU unchanged.
REQ-039 I/O: write 16'h00A5 to 16'hFFFF -> HEX_Data=16'h00A5, no SRAM strobe; then read 16'hFFFF with Switches=16'h0F0F -> Data_to_CPU=16'h0F0F.
REQ-040 Mem_OE held 10 cycles -> exactly one access and one Mem_Ready pulse; new access only after Mem_OE is low for at least one edge.
REQ-041 Reset asserted in 2nd strobe cycle of a read -> strobes inactive next cycle, no Mem_Ready, Data_to_CPU=0.
